// File: rtl/shift_unit_if.sv
// Operation/result bundle for shift_unit.
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high. The producer holds its payload stable while valid && !ready, and
// it never drops valid before the transfer. Ready may depend on the
// consumer's own ready.
interface shift_unit_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_n;
  logic [WIDTH-1:0] in_value;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_carry;
  logic             out_zero;
  logic             out_err;

  modport master (
    output in_valid, in_op, in_n, in_value, out_ready,
    input  in_ready, out_valid, out_result, out_carry, out_zero, out_err
  );

  modport slave (
    input  in_valid, in_op, in_n, in_value, out_ready,
    output in_ready, out_valid, out_result, out_carry, out_zero, out_err
  );
endinterface

// File: rtl/shift_unit.sv
// Two-stage shift/rotate unit.
// S1 registers the operand after applying the upper half of the amount bits.
// S2 applies the lower half, then registers the result and flags.
// Logical and arithmetic shifts carry one extra bit beside the operand. That
// bit catches the last bit shifted out, so the carry survives the split shift.
// SHL uses the layout {carry, value}. SHR and SRA use {value, carry}.
module shift_unit #(
  parameter int WIDTH = 16
) (
  input logic         clk,
  input logic         rst_n,
  shift_unit_if.slave bus
);
  localparam int SH_W = $clog2(WIDTH);
  localparam int LO_W = SH_W / 2;
  localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);

  localparam logic [2:0] OP_ROR = 3'b000;
  localparam logic [2:0] OP_ROL = 3'b001;
  localparam logic [2:0] OP_SHL = 3'b010;
  localparam logic [2:0] OP_SHR = 3'b011;
  localparam logic [2:0] OP_SRA = 3'b100;

  logic             s1_valid_q;
  logic [2:0]       s1_op_q;
  logic [WIDTH:0]   s1_ext_q, s1_ext_d;
  logic [LO_W-1:0]  s1_lo_q, s1_lo_d;
  logic             s1_rzero_q, s1_rzero_d;

  logic             out_valid_q;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;

  logic [SH_W-1:0]    amt;
  logic [SH_W-1:0]    hi_amt;
  logic               sat_eq, sat_gt;
  logic [2*WIDTH-1:0] dbl1, dbl2;
  logic [WIDTH:0]     sh_t;
  logic               s2_take;
  logic               in_ready_w;

  // S2 takes a new entry when it is empty or its result leaves this cycle.
  assign s2_take    = !out_valid_q || bus.out_ready;
  assign in_ready_w = rst_n && (!s1_valid_q || s2_take);

  assign bus.in_ready   = in_ready_w;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = result_q;
  assign bus.out_carry  = carry_q;
  assign bus.out_zero   = zero_q;
  assign bus.out_err    = err_q;

  // S1 datapath: saturate long shifts and apply the upper amount bits.
  always_comb begin
    amt        = bus.in_n[SH_W-1:0];
    hi_amt     = {amt[SH_W-1:LO_W], {LO_W{1'b0}}};
    sat_eq     = (bus.in_n == W_VAL);
    sat_gt     = (bus.in_n > W_VAL);
    dbl1       = {bus.in_value, bus.in_value};
    s1_ext_d   = {1'b0, bus.in_value};
    s1_lo_d    = amt[LO_W-1:0];
    s1_rzero_d = (amt == '0);
    case (bus.in_op)
      OP_ROR: begin
        dbl1     = {bus.in_value, bus.in_value} >> hi_amt;
        s1_ext_d = {1'b0, dbl1[WIDTH-1:0]};
      end
      OP_ROL: begin
        dbl1     = {bus.in_value, bus.in_value} << hi_amt;
        s1_ext_d = {1'b0, dbl1[2*WIDTH-1:WIDTH]};
      end
      OP_SHL: begin
        if (sat_gt) begin
          s1_ext_d = '0;
          s1_lo_d  = '0;
        end else if (sat_eq) begin
          s1_ext_d = {bus.in_value[0], {WIDTH{1'b0}}};
          s1_lo_d  = '0;
        end else begin
          s1_ext_d = {1'b0, bus.in_value} << hi_amt;
        end
      end
      OP_SHR: begin
        if (sat_gt) begin
          s1_ext_d = '0;
          s1_lo_d  = '0;
        end else if (sat_eq) begin
          s1_ext_d = {{WIDTH{1'b0}}, bus.in_value[WIDTH-1]};
          s1_lo_d  = '0;
        end else begin
          s1_ext_d = {bus.in_value, 1'b0} >> hi_amt;
        end
      end
      OP_SRA: begin
        if (sat_gt || sat_eq) begin
          s1_ext_d = {(WIDTH+1){bus.in_value[WIDTH-1]}};
          s1_lo_d  = '0;
        end else begin
          s1_ext_d = $signed({bus.in_value, 1'b0}) >>> hi_amt;
        end
      end
      default: begin
        s1_lo_d = '0;
      end
    endcase
  end

  // S1 register: load on input transfer, go empty when the entry moves on.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_ext_q   <= '0;
      s1_lo_q    <= '0;
      s1_rzero_q <= 1'b0;
    end else if (in_ready_w) begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_op_q    <= bus.in_op;
        s1_ext_q   <= s1_ext_d;
        s1_lo_q    <= s1_lo_d;
        s1_rzero_q <= s1_rzero_d;
      end
    end
  end

  // S2 datapath: apply the lower amount bits, then extract the result and flags.
  always_comb begin
    dbl2     = {s1_ext_q[WIDTH-1:0], s1_ext_q[WIDTH-1:0]};
    sh_t     = s1_ext_q;
    result_d = s1_ext_q[WIDTH-1:0];
    carry_d  = 1'b0;
    err_d    = 1'b0;
    case (s1_op_q)
      OP_ROR: begin
        dbl2     = {s1_ext_q[WIDTH-1:0], s1_ext_q[WIDTH-1:0]} >> s1_lo_q;
        result_d = dbl2[WIDTH-1:0];
        carry_d  = !s1_rzero_q && dbl2[WIDTH-1];
      end
      OP_ROL: begin
        dbl2     = {s1_ext_q[WIDTH-1:0], s1_ext_q[WIDTH-1:0]} << s1_lo_q;
        result_d = dbl2[2*WIDTH-1:WIDTH];
        carry_d  = !s1_rzero_q && dbl2[WIDTH];
      end
      OP_SHL: begin
        sh_t     = s1_ext_q << s1_lo_q;
        result_d = sh_t[WIDTH-1:0];
        carry_d  = sh_t[WIDTH];
      end
      OP_SHR: begin
        sh_t     = s1_ext_q >> s1_lo_q;
        result_d = sh_t[WIDTH:1];
        carry_d  = sh_t[0];
      end
      OP_SRA: begin
        sh_t     = $signed(s1_ext_q) >>> s1_lo_q;
        result_d = sh_t[WIDTH:1];
        carry_d  = sh_t[0];
      end
      default: begin
        err_d = 1'b1;
      end
    endcase
    zero_d = (result_d == '0);
  end

  // Output register: hold the result while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
    end else if (s2_take) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        result_q <= result_d;
        carry_q  <= carry_d;
        zero_q   <= zero_d;
        err_q    <= err_d;
      end
    end
  end
endmodule

// File: tb/tb_shift_unit.sv
// Directed bench for shift_unit (WIDTH=16). The driver pushes hand-computed
// expectations as each operation is accepted. The monitor pops and compares
// every output transfer. It also checks that outputs stay stable while
// the output is stalled.
module tb_shift_unit;
  localparam int W  = 16;
  localparam int EW = W + 3;

  localparam logic [2:0] ROR = 3'b000;
  localparam logic [2:0] ROL = 3'b001;
  localparam logic [2:0] SHL = 3'b010;
  localparam logic [2:0] SHR = 3'b011;
  localparam logic [2:0] SRA = 3'b100;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  shift_unit_if #(.WIDTH(W)) bus ();
  shift_unit #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // clock
  always #5 clk = ~clk;

  int checks  = 0;
  int errors  = 0;
  int pop_cnt = 0;
  int pops0;
  logic [EW-1:0] exp_q[$];

  logic          held = 1'b0;
  logic [EW-1:0] last_out = '0;
  logic [EW-1:0] cur_out;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // monitor: samples mid-cycle, after the driver has settled for the coming edge
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        held = 1'b0;
      end else begin
        cur_out = {bus.out_result, bus.out_carry, bus.out_zero, bus.out_err};
        if (held) check("stall_hold", {bus.out_valid, cur_out}, {1'b1, last_out});
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output actual=%0h required=none", cur_out);
          end else begin
            check("result", cur_out, exp_q.pop_front());
          end
          pop_cnt++;
          held = 1'b0;
        end else if (bus.out_valid) begin
          held     = 1'b1;
          last_out = cur_out;
        end else begin
          held = 1'b0;
        end
      end
    end
  end

  // driver: call at a negedge; returns at the negedge after the transfer
  task automatic send(input logic [2:0] op, input logic [W-1:0] n, input logic [W-1:0] v,
                      input logic [W-1:0] er, input logic ec, input logic ez, input logic ee);
    int guard;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_n     = n;
    bus.in_value = v;
    #1;
    guard = 0;
    while (!bus.in_ready && guard < 40) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=in_ready_low required=in_ready_high");
    end else begin
      exp_q.push_back({er, ec, ez, ee});
    end
    @(negedge clk);
  endtask

  task automatic idle(input int cycles);
    bus.in_valid = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_n      = '0;
    bus.in_value  = '0;
    bus.out_ready = 1'b1;

    // reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_result", bus.out_result, 0);
    check("rst_flags", {bus.out_carry, bus.out_zero, bus.out_err}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_rst", bus.in_ready, 1);

    // latency: result visible two cycles after the transfer
    send(ROR, 16'd1, 16'h8001, 16'hC000, 1'b1, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    check("latency_early", bus.out_valid, 0);
    @(negedge clk);
    check("latency_2", bus.out_valid, 1);
    idle(3);

    // directed vectors, back to back
    send(ROL, 16'd20,    16'h8001, 16'h0018, 1'b0, 1'b0, 1'b0);
    send(SHR, 16'd4,     16'h00F0, 16'h000F, 1'b0, 1'b0, 1'b0);
    send(SHL, 16'd16,    16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0);
    send(SRA, 16'd20,    16'h8000, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    send(SHR, 16'd0,     16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    send(3'b110, 16'd3,  16'h1234, 16'h1234, 1'b0, 1'b0, 1'b1);
    send(SHL, 16'd6,     16'h8421, 16'h0840, 1'b1, 1'b0, 1'b0);
    send(SRA, 16'd1,     16'h8421, 16'hC210, 1'b1, 1'b0, 1'b0);
    send(ROR, 16'd16,    16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0);
    send(ROL, 16'd1,     16'h8001, 16'h0003, 1'b1, 1'b0, 1'b0);
    send(SHR, 16'd1,     16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0);
    send(SHR, 16'hFFFF,  16'h1234, 16'h0000, 1'b0, 1'b1, 1'b0);
    send(SHL, 16'd17,    16'h8000, 16'h0000, 1'b0, 1'b1, 1'b0);
    send(SRA, 16'd16,    16'h7FFF, 16'h0000, 1'b0, 1'b1, 1'b0);
    send(3'b111, 16'd0,  16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1);
    send(ROR, 16'd17,    16'h0001, 16'h8000, 1'b1, 1'b0, 1'b0);
    send(SHR, 16'd13,    16'hF000, 16'h0007, 1'b1, 1'b0, 1'b0);
    send(SHL, 16'd8,     16'h00FF, 16'hFF00, 1'b0, 1'b0, 1'b0);
    idle(4);
    check("drain_directed", exp_q.size(), 0);

    // backpressure: two ops fit, the third waits
    bus.out_ready = 1'b0;
    send(SHL, 16'd4, 16'h00FF, 16'h0FF0, 1'b0, 1'b0, 1'b0);
    send(SHR, 16'd4, 16'h00FF, 16'h000F, 1'b1, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_op    = ROL;
    bus.in_n     = 16'd4;
    bus.in_value = 16'h0F00;
    #1;
    check("bp_in_ready_third", bus.in_ready, 0);
    repeat (3) @(negedge clk);
    #1;
    check("bp_in_ready_hold", bus.in_ready, 0);
    check("bp_out_valid_hold", bus.out_valid, 1);
    @(negedge clk);
    pops0 = pop_cnt;
    bus.out_ready = 1'b1;
    send(ROL, 16'd4, 16'h0F00, 16'hF000, 1'b0, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    #3;
    check("bp_release_count", pop_cnt - pops0, 3);
    idle(3);
    check("drain_bp", exp_q.size(), 0);

    // reset with two ops in flight, plus an op offered during reset
    bus.out_ready = 1'b0;
    send(SHL, 16'd1, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0);
    send(SHR, 16'd1, 16'h0004, 16'h0002, 1'b0, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_op    = SHL;
    bus.in_n     = 16'd2;
    bus.in_value = 16'h0001;
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_out_result", bus.out_result, 0);
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", bus.in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      check("midrst_no_output", bus.out_valid, 0);
      @(negedge clk);
    end
    send(SHL, 16'd1, 16'h0003, 16'h0006, 1'b0, 1'b0, 1'b0);
    idle(4);
    check("drain_final", exp_q.size(), 0);
    check("pop_total", pop_cnt, 23);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
